// File: rtl/ember_pkg.sv
// Shared types and constants for the Ember fetch path: instruction geometry,
// fetch FSM states and the instruction field layout used by decode.
package ember_pkg;

    localparam int INST_W         = 32;
    localparam int BYTES_PER_INST = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PUSH
    } fetch_state_e;

    typedef struct packed {
        logic [11:0] imm;
        logic [3:0]  fn;
        logic [5:0]  rs;
        logic [5:0]  rd;
        logic [3:0]  opcode;
    } inst_fields_t;

    function automatic inst_fields_t inst_fields(input logic [INST_W-1:0] w);
        return inst_fields_t'(w);
    endfunction

endpackage

// File: rtl/ember_inst_fifo.sv
// Synchronous instruction queue holding {pc, word} pairs; flush empties it in one cycle.
// The head outputs read as zero while the queue is empty.
module ember_inst_fifo #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [ADDR_W-1:0]        head_pc,
    output logic [DATA_W-1:0]        head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    assign head_pc   = empty ? '0 : pc_mem[rd_ptr];
    assign head_data = empty ? '0 : data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]   <= push_pc;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ember_fetch_unit.sv
// Ember instruction fetch: assembles little-endian words from byte reads of L3 and queues
// {pc, inst} for decode. Define EMBER_FETCH_STATS_EN to add the fetched/flushed counters.
module ember_fetch_unit
    import ember_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [7:0]         mem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INST_W-1:0]  inst_data,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef EMBER_FETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_flushed
`endif
);

    localparam int              CNT_W     = $clog2(DEPTH) + 1;
    localparam int              BC_W      = $clog2(BYTES_PER_INST);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_INST - 1);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [BC_W-1:0]   byte_cnt;
    logic              discard;
    logic [INST_W-1:0] word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              space_after;
    logic [CNT_W-1:0]  count;

    assign inst_valid  = !fifo_empty;
    assign pop         = inst_valid && inst_ready;
    assign push        = (state == ST_PUSH) && !redirect_valid;
    // Room for another word once this cycle's push and pop have both landed.
    assign space_after = (count - CNT_W'(pop)) < CNT_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            byte_cnt <= '0;
            discard  <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (redirect_valid) begin
            state    <= ST_FETCH;
            pc       <= redirect_pc & ~ADDR_W'(3);
            byte_cnt <= '0;
            // An unacknowledged request must stay up; its byte is dropped when it returns.
            if (mem_req && !mem_ack) begin
                discard <= 1'b1;
            end else begin
                discard <= 1'b0;
                mem_req <= 1'b0;
            end
        end else if (discard) begin
            if (mem_ack) begin
                discard <= 1'b0;
                mem_req <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_full || pop) begin
                        state    <= ST_FETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                ST_FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc + ADDR_W'(byte_cnt);
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            state    <= ST_PUSH;
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end
                ST_PUSH: begin
                    pc <= pc + ADDR_W'(BYTES_PER_INST);
                    if (space_after) begin
                        state    <= ST_FETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= pc + ADDR_W'(BYTES_PER_INST);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_FETCH && mem_req && mem_ack && !discard && !redirect_valid)
            word[{byte_cnt, 3'b000} +: 8] <= mem_rdata;
    end

    ember_inst_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_pc   (pc),
        .push_data (word),
        .pop       (pop),
        .head_pc   (inst_pc),
        .head_data (inst_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

`ifdef EMBER_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            if (push)           stat_fetched <= stat_fetched + 32'd1;
            if (redirect_valid) stat_flushed <= stat_flushed + 32'(count);
        end
    end
`endif

endmodule

// File: tb/tb_ember_fetch_unit.sv
// Bench for ember_fetch_unit: directed vectors, wrap instance, redirect/reset corners and a
// randomized run checked against an in-order instruction-stream model.
module tb_ember_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        w_mem_req, w_mem_ack;
    logic [31:0] w_mem_addr;
    logic [7:0]  w_mem_rdata;
    logic        w_inst_valid;
    logic        w_inst_ready = 1'b1;
    logic [31:0] w_inst_data, w_inst_pc;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc = 32'd0;

`ifdef EMBER_FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_flushed, w_stat_fetched, w_stat_flushed;
`endif

    ember_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef EMBER_FETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
    );

    ember_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst_data(w_inst_data),
        .inst_pc(w_inst_pc), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
`ifdef EMBER_FETCH_STATS_EN
        , .stat_fetched(w_stat_fetched), .stat_flushed(w_stat_flushed)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem [256];
    int          fixed_dly = 0;
    bit          rand_dly = 1'b0;
    int          wcnt = 0;
    int          cur_dly = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        prev_rst = 1'b0;
    logic [31:0] req_log[$], pop_pc_q[$], pop_data_q[$];
    logic [31:0] w_req_log[$], w_pop_pc_q[$], w_pop_data_q[$];

    typedef struct {
        int          dly;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;
    vec_t vt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    // One clock: L3 responders and pop monitor act on this cycle's values, then the edge passes.
    task automatic tick();
        if (prev_hold && prev_rst) begin
            check("hold_req", 32'(mem_req), 32'd1);
            check("hold_addr", mem_addr, prev_addr);
        end
        if (mem_req) begin
            if (wcnt == 0) cur_dly = rand_dly ? int'($urandom_range(0, 3)) : fixed_dly;
            if (wcnt >= cur_dly) begin
                mem_ack = 1'b1;
                wcnt = 0;
                if (rst) req_log.push_back(mem_addr);
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
        mem_rdata = mem[mem_addr[7:0]];
        prev_hold = mem_req && !mem_ack;
        prev_addr = mem_addr;
        prev_rst  = rst;
        w_mem_ack   = w_mem_req;
        w_mem_rdata = mem[w_mem_addr[7:0]];
        if (rst && w_mem_req) w_req_log.push_back(w_mem_addr);
        if (rst && inst_valid && inst_ready && !redirect_valid) begin
            pop_pc_q.push_back(inst_pc);
            pop_data_q.push_back(inst_data);
        end
        if (rst && w_inst_valid) begin
            w_pop_pc_q.push_back(w_inst_pc);
            w_pop_data_q.push_back(w_inst_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc_q.delete();
        pop_data_q.delete();
        w_req_log.delete();
        w_pop_pc_q.delete();
        w_pop_data_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic expect_pop(input string name, input logic [31:0] epc, input logic [31:0] edata);
        int n = 0;
        while (pop_pc_q.size() == 0 && n < 200) begin
            tick();
            n++;
        end
        if (pop_pc_q.size() == 0) begin
            check({name, "_timeout"}, 32'(pop_pc_q.size()), 32'd1);
        end else begin
            check({name, "_pc"}, pop_pc_q.pop_front(), epc);
            check({name, "_data"}, pop_data_q.pop_front(), edata);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst_data"}, inst_data, 32'd0);
        check({tag, "_inst_pc"}, inst_pc, 32'd0);
    endtask

    initial begin
        logic [31:0] xv;
        logic [31:0] exp_pc;
        logic [31:0] w_exp [8];
        int          n;
        int          npops;
        bit          redir;

        xv = 'x;
        rst = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        w_mem_ack = 1'b0;
        w_mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h11; mem[1] = 8'h20; mem[2] = 8'h52; mem[3] = 8'h11;
        mem[4] = 8'h21; mem[5] = 8'h04; mem[6] = 8'h11; mem[7] = 8'h00;

        vt[0] = '{dly: 0, pc: 32'h0, inst: 32'h1152_2011};
        vt[1] = '{dly: 0, pc: 32'h4, inst: 32'h0011_0421};
        vt[2] = '{dly: 3, pc: 32'h0, inst: 32'h1152_2011};
        vt[3] = '{dly: 3, pc: 32'h4, inst: 32'h0011_0421};

        @(negedge clk);

        // Reset values
        tick();
        tick();
        check_reset_outputs("reset");

        // First-instruction latency with single-cycle ack, plus the wrapping instance
        inst_ready = 1'b1;
        fixed_dly = 0;
        rst = 1'b1;
        clear_logs();
        n = 0;
        while (!inst_valid && n < 40) begin
            tick();
            n++;
        end
        check("first_valid_latency", n, 32'd9);
        repeat (20) tick();
        w_exp = '{32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                  32'h0, 32'h1, 32'h2, 32'h3};
        for (int i = 0; i < 8; i++)
            check("wrap_req_addr", (i < w_req_log.size()) ? w_req_log[i] : xv, w_exp[i]);
        check("wrap_pc0", (w_pop_pc_q.size() > 0) ? w_pop_pc_q[0] : xv, 32'hFFFF_FFFC);
        check("wrap_data0", (w_pop_data_q.size() > 0) ? w_pop_data_q[0] : xv, word_at(32'hFFFF_FFFC));
        check("wrap_pc1", (w_pop_pc_q.size() > 1) ? w_pop_pc_q[1] : xv, 32'h0);
        check("wrap_data1", (w_pop_data_q.size() > 1) ? w_pop_data_q[1] : xv, word_at(32'h0));

        // Directed vectors: immediate and 3-cycle-delayed acks
        for (int i = 0; i < 4; i++) begin
            if (vt[i].pc == 32'h0) begin
                fixed_dly = vt[i].dly;
                inst_ready = 1'b1;
                do_reset();
            end
            expect_pop($sformatf("vec%0d", i), vt[i].pc, vt[i].inst);
        end

        // Back-pressure: queue fills to DEPTH and fetch stops
        fixed_dly = 0;
        inst_ready = 1'b0;
        do_reset();
        repeat (60) tick();
        check("full_req_count", 32'(req_log.size()), 32'd16);
        check("full_mem_req", 32'(mem_req), 32'd0);
        check("full_valid", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            expect_pop($sformatf("drain%0d", i), 32'(i * 4), word_at(32'(i * 4)));

        // Redirect while a byte request is outstanding
        fixed_dly = 3;
        inst_ready = 1'b0;
        do_reset();
        n = 0;
        while (!(mem_req && mem_addr == 32'h6) && n < 100) begin
            tick();
            n++;
        end
        check("redir_reached_byte2", mem_addr, 32'h6);
        check("redir_queue_before", 32'(inst_valid), 32'd1);
        req_log.delete();
        redirect_valid = 1'b1;
        redirect_pc = 32'h13;
        tick();
        redirect_valid = 1'b0;
        check("redir_queue_flushed", 32'(inst_valid), 32'd0);
        check("redir_req_held", 32'(mem_req), 32'd1);
        check("redir_addr_held", mem_addr, 32'h6);
        n = 0;
        while (req_log.size() < 2 && n < 30) begin
            tick();
            n++;
        end
        check("redir_old_ack_addr", (req_log.size() > 0) ? req_log[0] : xv, 32'h6);
        check("redir_new_addr", (req_log.size() > 1) ? req_log[1] : xv, 32'h10);
        pop_pc_q.delete();
        pop_data_q.delete();
        inst_ready = 1'b1;
        expect_pop("redir_first", 32'h10, word_at(32'h10));

        // Reset in the middle of a fetch
        fixed_dly = 3;
        do_reset();
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        tick();
        check("midreset_req_before", 32'(mem_req), 32'd1);
        rst = 1'b0;
        tick();
        check_reset_outputs("midreset");

        // Randomized acks, back-pressure and redirects against an in-order stream model
        rand_dly = 1'b1;
        do_reset();
        exp_pc = 32'h0;
        npops = 0;
        for (int c = 0; c < 3000; c++) begin
            inst_ready = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 99) < 3);
            redirect_valid = redir;
            if (redir) redirect_pc = $urandom;
            tick();
            while (pop_pc_q.size() > 0) begin
                check("rand_pc", pop_pc_q.pop_front(), exp_pc);
                check("rand_data", pop_data_q.pop_front(), word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                npops++;
            end
            if (redir) exp_pc = redirect_pc & ~32'd3;
        end
        redirect_valid = 1'b0;
        check("rand_progress", 32'(npops > 40), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
